// File: rtl/scs8hd_einv_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : scs8hd_einv_bus_arb
// Purpose  : Round-robin TE arbiter for a shared tristate-inverter bus with
//            break-before-make dead time, tenure preemption and kill.
// Revision : 1.0
// ============================================================================
module scs8hd_einv_bus_arb #(
  parameter int N        = 4,
  parameter int DEAD_CYC = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RESETB,
  input  logic [N-1:0]         req,
  input  logic                 kill,
  output logic [N-1:0]         te,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int              c_OWNER_W   = $clog2(N);
  localparam int              c_SUM_W     = c_OWNER_W + 1;
  localparam logic [c_OWNER_W-1:0] c_LAST_IDX = c_OWNER_W'(N - 1);
  localparam logic [N-1:0]    c_ONE       = N'(1);
  localparam logic [3:0]      c_DEAD_LAST = 4'(DEAD_CYC - 1);
  localparam logic [7:0]      c_HOLD_SAT  = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_DEAD  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [c_OWNER_W-1:0]   r_owner;
  logic [c_OWNER_W-1:0]   w_owner_nxt;
  logic [7:0]             r_hold;
  logic [7:0]             w_hold_nxt;
  logic [3:0]             r_dead;
  logic [3:0]             w_dead_nxt;
  logic [N-1:0]           r_te;
  logic                   r_first;
  logic                   w_grant;

  logic [c_OWNER_W-1:0]   w_start;
  logic [c_SUM_W-1:0]     w_sum;
  logic [c_OWNER_W-1:0]   w_win;
  logic                   w_found;
  logic [N-1:0]           w_owner_oh;
  logic                   w_other;
  logic                   w_preempt;

  // Round-robin search from owner+1 (index 0 straight out of reset), mod N.
  always_comb begin
    w_start = r_first ? '0 : ((r_owner == c_LAST_IDX) ? '0 : r_owner + c_OWNER_W'(1));
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < N; i++) begin
      w_sum = {1'b0, w_start} + c_SUM_W'(i);
      if (w_sum >= c_SUM_W'(N)) begin
        w_sum = w_sum - c_SUM_W'(N);
      end
      if (!w_found && req[w_sum[c_OWNER_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[c_OWNER_W-1:0];
      end
    end
  end

  assign w_owner_oh = c_ONE << r_owner;
  assign w_other    = |(req & ~w_owner_oh);
  assign w_preempt  = (MAX_HOLD != 0) && (r_hold == c_HOLD_SAT) && w_other;

  always_comb begin
    w_next      = r_state;
    w_owner_nxt = r_owner;
    w_hold_nxt  = r_hold;
    w_dead_nxt  = r_dead;
    w_grant     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!kill && w_found) begin
          w_grant = 1'b1;
        end
      end
      S_GRANT: begin
        if (!req[r_owner] || kill || w_preempt) begin
          w_next     = S_DEAD;
          w_dead_nxt = '0;
        end else if (w_other && (r_hold != c_HOLD_SAT)) begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end
      S_DEAD: begin
        // A kill held at the end of the window keeps the bus dark in DEAD.
        if (r_dead == c_DEAD_LAST) begin
          if (!kill) begin
            if (w_found) begin
              w_grant = 1'b1;
            end else begin
              w_next = S_IDLE;
            end
          end
        end else begin
          w_dead_nxt = r_dead + 4'd1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_grant) begin
      w_next      = S_GRANT;
      w_owner_nxt = w_win;
      w_hold_nxt  = '0;
    end
  end

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_hold  <= '0;
      r_dead  <= '0;
      r_te    <= '0;
      r_first <= 1'b1;
    end else begin
      r_state <= w_next;
      r_owner <= w_owner_nxt;
      r_hold  <= w_hold_nxt;
      r_dead  <= w_dead_nxt;
      r_te    <= (w_next == S_GRANT) ? (c_ONE << w_owner_nxt) : '0;
      if (w_grant) begin
        r_first <= 1'b0;
      end
    end
  end

  assign te    = r_te;
  assign owner = r_owner;
  assign busy  = (r_state != S_IDLE);

`ifndef SYNTHESIS
  localparam logic [4:0] c_DEAD_CHK = 5'(DEAD_CYC);
  logic [4:0]   r_chk_off;
  logic [N-1:0] r_chk_te;

  always_comb begin
    assert ($countones(te) <= 1);
  end

  // Counts consecutive all-off samples to prove the break-before-make gap.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_chk_off <= 5'd31;
      r_chk_te  <= '0;
    end else begin
      if ((te != '0) && (r_chk_te == '0)) begin
        assert (r_chk_off >= c_DEAD_CHK);
      end
      if ((te != '0) && (r_chk_te != '0)) begin
        assert (te == r_chk_te);
      end
      r_chk_te <= te;
      if (te != '0) begin
        r_chk_off <= '0;
      end else if (r_chk_off != 5'd31) begin
        r_chk_off <= r_chk_off + 5'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_scs8hd_einv_bus_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_scs8hd_einv_bus_arb
// Purpose  : Randomized bench for two arbiter configurations against a
//            behavioural bus-ownership model.
// Revision : 1.0
// ============================================================================
module tb_scs8hd_einv_bus_arb;

  localparam int N_A = 4, DC_A = 2, MH_A = 16;
  localparam int N_B = 3, DC_B = 3, MH_B = 4;

  logic           clk    = 1'b0;
  logic           resetb = 1'b0;
  logic           kill   = 1'b0;
  logic [N_A-1:0] req_a  = '0;
  logic [N_B-1:0] req_b  = '0;
  logic [N_A-1:0] te_a;
  logic [N_B-1:0] te_b;
  logic [1:0]     owner_a;
  logic [1:0]     owner_b;
  logic           busy_a;
  logic           busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  // phase: 0 bus free, 1 someone owns it, 2 enforced off-time after a release
  typedef struct packed {
    int phase;
    int own;
    int waited;
    int gap;
    bit fresh;
  } mstate_t;

  mstate_t ma, mb;

  scs8hd_einv_bus_arb #(.N(N_A), .DEAD_CYC(DC_A), .MAX_HOLD(MH_A)) u_dut_a (
    .CLK(clk), .RESETB(resetb), .req(req_a), .kill(kill),
    .te(te_a), .owner(owner_a), .busy(busy_a)
  );

  scs8hd_einv_bus_arb #(.N(N_B), .DEAD_CYC(DC_B), .MAX_HOLD(MH_B)) u_dut_b (
    .CLK(clk), .RESETB(resetb), .req(req_b), .kill(kill),
    .te(te_b), .owner(owner_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  function automatic mstate_t m_reset();
    mstate_t s;
    s.phase  = 0;
    s.own    = 0;
    s.waited = 0;
    s.gap    = 0;
    s.fresh  = 1'b1;
    return s;
  endfunction

  function automatic mstate_t m_step(mstate_t s, logic [15:0] rq, bit kl, int n, int dc, int mh);
    mstate_t r = s;
    bit others = 1'b0;
    int win = -1;
    int start;
    int cap;
    for (int j = 0; j < n; j++) begin
      if (rq[4'(j)] && (j != s.own)) others = 1'b1;
    end
    start = s.fresh ? 0 : (s.own + 1) % n;
    for (int k = 0; k < n; k++) begin
      int c;
      c = (start + k) % n;
      if ((win < 0) && rq[4'(c)]) win = c;
    end
    cap = (mh == 0) ? 255 : mh - 1;
    case (s.phase)
      0: begin
        if (!kl && (win >= 0)) begin
          r.phase = 1; r.own = win; r.waited = 0; r.fresh = 1'b0;
        end
      end
      1: begin
        if (!rq[4'(s.own)] || kl || ((mh != 0) && (s.waited == mh - 1) && others)) begin
          r.phase = 2;
          r.gap   = 1;
        end else if (others && (s.waited < cap)) begin
          r.waited = s.waited + 1;
        end
      end
      default: begin
        if (s.gap < dc) begin
          r.gap = s.gap + 1;
        end else if (!kl) begin
          if (win >= 0) begin
            r.phase = 1; r.own = win; r.waited = 0; r.fresh = 1'b0;
          end else begin
            r.phase = 0;
          end
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] exp_te(mstate_t s);
    return (s.phase == 1) ? (32'd1 << s.own) : 32'd0;
  endfunction

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("te_a",    32'(te_a),    exp_te(ma));
    chk("owner_a", 32'(owner_a), 32'(ma.own));
    chk("busy_a",  32'(busy_a),  32'(ma.phase != 0));
    chk("te_b",    32'(te_b),    exp_te(mb));
    chk("owner_b", 32'(owner_b), 32'(mb.own));
    chk("busy_b",  32'(busy_b),  32'(mb.phase != 0));
  endtask

  task automatic step(logic [15:0] ra, logic [15:0] rb, bit k);
    req_a = ra[N_A-1:0];
    req_b = rb[N_B-1:0];
    kill  = k;
    ma = m_step(ma, ra, k, N_A, DC_A, MH_A);
    mb = m_step(mb, rb, k, N_B, DC_B, MH_B);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    logic [15:0] sa;
    logic [15:0] sb;
    int          kill_left;
    bit          k;

    sa = '0;
    sb = '0;
    kill_left = 0;
    ma = m_reset();
    mb = m_reset();
    #2;
    check_all();
    @(posedge clk);
    #1;
    resetb = 1'b1;

    // single requester: grant, voluntary release, dead window, idle
    for (int i = 0; i < 5; i++) step(16'h1, 16'h1, 1'b0);
    for (int i = 0; i < 5; i++) step(16'h0, 16'h0, 1'b0);
    // handover between two requesters
    for (int i = 0; i < 4; i++) step(16'h3, 16'h3, 1'b0);
    for (int i = 0; i < 8; i++) step(16'h2, 16'h2, 1'b0);
    // preemption rotation with everyone holding
    for (int i = 0; i < 80; i++) step(16'h5, 16'h7, 1'b0);
    // kill burst mid-grant
    for (int i = 0; i < 5; i++) step(16'h5, 16'h7, 1'b0);
    for (int i = 0; i < 5; i++) step(16'h5, 16'h7, 1'b1);
    for (int i = 0; i < 12; i++) step(16'h5, 16'h7, 1'b0);

    // asynchronous reset between edges while granted
    for (int i = 0; i < 8; i++) step(16'h1, 16'h1, 1'b0);
    #3;
    resetb = 1'b0;
    #1;
    ma = m_reset();
    mb = m_reset();
    chk("te_a_async", 32'(te_a), 32'd0);
    check_all();
    @(posedge clk);
    #1;
    check_all();
    resetb = 1'b1;
    for (int i = 0; i < 3; i++) step(16'h8, 16'h4, 1'b0);

    // sticky random requests, periodic all-request phases, kill bursts
    for (int c = 0; c < 2500; c++) begin
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 9) == 0) sa = sa ^ (16'd1 << b);
        if ($urandom_range(0, 9) == 0) sb = sb ^ (16'd1 << b);
      end
      if (kill_left > 0) begin
        kill_left--;
      end else if ($urandom_range(0, 63) == 0) begin
        kill_left = int'($urandom_range(1, 6));
      end
      k = (kill_left > 0);
      if (((c / 100) % 4) == 3) begin
        step(16'hFFFF, 16'hFFFF, k);
      end else begin
        step(sa, sb, k);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
